machine_result_aggregator: RTL and testbench
============================================

# machine_result_aggregator

Parametrised multi-channel result collector that sits between an array of machine compute units and the `tap_encoder`. It buffers one result per channel, merges the channels through a round-robin arbiter into a single wide accumulator, and tracks completion by matching dispatched machines against returned results. It also flags overflow and protocol violations. It replaces the single-stream inline accumulator in the user-logic top level.

## Interface
- `NUM_CHANNELS`, 4: number of compute-unit result streams (1..16)
- `RESULT_WIDTH`, 16: width of each per-machine result
- `ACC_WIDTH`, 32: accumulator width; must be ≥ RESULT_WIDTH
- `COUNT_WIDTH`, 10: width of the dispatched and returned machine counters

- `clk`  in  1  sole clock (TCK domain)
- `test_logic_reset_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous clear of accumulator, counters, flags and pending slots
- `machine_dispatched`  in  1  one-cycle pulse per machine handed to any compute unit
- `end_of_file`  in  1  held high once the last machine has been dispatched
- `result_valid`  in  NUM_CHANNELS  per-channel one-cycle result strobe
- `result_data`  in  NUM_CHANNELS*RESULT_WIDTH  channel i occupies bits [i*RESULT_WIDTH +: RESULT_WIDTH]
- `channel_busy`  out  NUM_CHANNELS  pending slot i is occupied
- `sum_valid`  out  1  completion flag; held high until clear or reset
- `sum_data`  out  ACC_WIDTH  running accumulated sum
- `result_count`  out  COUNT_WIDTH  number of results accumulated so far
- `overflow`  out  1  sticky; accumulator carry-out occurred
- `protocol_error`  out  1  sticky; a result was dropped, arrived late, or a counter saturated

## Operation
- **Reset and clear.** Reset (async) or `clear` (sync) drive every output to 0 and empty all pending slots. `clear` has priority over all other inputs in the same cycle. Inputs in a clear cycle are discarded and do not set `protocol_error`.
- **Pending slots.**
  - Each channel has a one-deep slot holding data and an occupied bit.
  - `result_valid[i]` with slot i empty: capture the data.
  - `result_valid[i]` with slot i occupied and not granted this cycle: drop the new data and set `protocol_error`.
  - `result_valid[i]` with slot i granted this cycle: the old value is accumulated and the new value is captured. No loss.
- **Arbiter.**
  - Round-robin across occupied slots; at most one grant per cycle.
  - The priority pointer starts at channel 0 after reset or clear.
  - After a grant to channel i, the pointer moves to (i+1) mod NUM_CHANNELS.
  - With no grant, the pointer holds.
- **Accumulation.**
  - `sum_data` ← `sum_data` + zero-extended granted data, modulo 2^ACC_WIDTH.
  - A carry-out sets `overflow`.
  - `result_count` increments on each grant.
- **Dispatch counting.**
  - An internal `dispatched_count` increments on `machine_dispatched`.
  - It saturates at 2^COUNT_WIDTH−1; an attempted increment past saturation sets `protocol_error`.
  - `result_count` saturates the same way.
- **Completion FSM.**
  - States: IDLE, COLLECT, DONE.
  - IDLE→COLLECT on the first `machine_dispatched` or `result_valid`.
  - IDLE or COLLECT → DONE when all of the following hold: `end_of_file`, `dispatched_count` = `result_count`, and every slot is empty.
  - With zero machines and `end_of_file` high, IDLE→DONE directly with `sum_data` = 0.
  - DONE holds until clear or reset.
  - In DONE, any `result_valid` or `machine_dispatched` sets `protocol_error` and is otherwise ignored.
- `sum_valid` = (state == DONE), registered.

## Timing
- `result_valid[i]` sampled at edge t → `channel_busy[i]` high after edge t.
- Earliest grant is in cycle t+1, so `sum_data` and `result_count` update at edge t+1 (2-cycle latency from strobe to sum).
- Worst-case drain time with all slots occupied is NUM_CHANNELS cycles.
- Completion condition true during cycle c → state becomes DONE at edge c, so `sum_valid` is high from cycle c+1. `sum_data` is final no later than the cycle `sum_valid` rises.
- `overflow` and `protocol_error` assert at the edge after the causing event and stay high until clear or reset.
- Reset asserted mid-run: all outputs go to 0 asynchronously, with no dependency on `clk`.

## Structure
- Shared package `aggregator_pkg`:
  - default widths (RESULT_WIDTH = 16, ACC_WIDTH = 32, COUNT_WIDTH = 10);
  - the FSM state enum `agg_state_t`;
  - a function `next_rr_index` used by the arbiter.
- Sub-module `rr_arbiter`, parameterised by `NUM_CHANNELS`: inputs are the request vector and the grant-accepted strobe; output is a one-hot grant. It holds its own pointer and uses the same clock and reset.
- Accumulator, counters and FSM are in the top block. The top level instantiates this block in place of its inline adder and feeds `sum_data[RESULT_WIDTH-1:0]` (or the full width) into `tap_encoder`.

## Test plan
1. **Single channel sequence.** 3 dispatches; results 5, 7, 11 on ch0, with `end_of_file` rising after the last dispatch → `sum_data` = 23, `result_count` = 3, `sum_valid` rises; no flags.
2. **Simultaneous results, 4 channels.** Strobe results 1, 2, 3, 4 on channels 0–3 in the same cycle → grants in order ch0..ch3 on 4 consecutive cycles; `sum_data` = 10 by edge t+4; `channel_busy` clears one bit per cycle.
3. **Round-robin fairness.** ch1 and ch2 re-strobe every cycle they are granted → grants alternate 1, 2, 1, 2; no `protocol_error`.
4. **Overflow with ACC_WIDTH = 16.** Results 0xFFFF then 0x0002 → `sum_data` = 0x0001, `overflow` = 1.
5. **Drop and late result.**
   - Second strobe on ch0 while its slot is occupied and ch3 holds the grant → `protocol_error` = 1 and only the first value is accumulated.
   - After DONE, any strobe → `protocol_error` = 1 and `sum_data` unchanged.
6. **Reset and clear mid-run.**
   - Assert `test_logic_reset_n` = 0 asynchronously between edges → all outputs 0 immediately.
   - `clear` concurrent with `result_valid` → sum stays 0 and no error is flagged.

Source files
------------

// File: rtl/aggregator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aggregator_pkg
// Brief    : Shared widths, completion-FSM state type and the round-robin
//            pointer helper for the machine result aggregator.
// Revision : 1.0 - initial release
// ============================================================================
package aggregator_pkg;

    localparam int unsigned c_default_result_width = 16;
    localparam int unsigned c_default_acc_width    = 32;
    localparam int unsigned c_default_count_width  = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } agg_state_t;

    // Channel that takes top priority after channel idx has been served.
    function automatic int unsigned next_rr_index(input int unsigned idx,
                                                  input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter, one-hot grant, at most one grant per cycle.
//            The priority pointer moves past the served channel only when the
//            grant is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import aggregator_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4
) (
    input  logic                    clk,
    input  logic                    test_logic_reset_n,
    input  logic                    clear,
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic                    accept,
    output logic [NUM_CHANNELS-1:0] grant
);

    localparam int unsigned c_ptr_width = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [c_ptr_width-1:0]  r_ptr;
    logic [c_ptr_width-1:0]  w_idx;
    logic [c_ptr_width-1:0]  w_grant_idx;
    logic                    w_grant_any;
    logic [NUM_CHANNELS-1:0] w_grant;

    // Scan requests starting at the priority pointer; the first hit wins.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            w_idx = c_ptr_width'((32'(r_ptr) + k) % NUM_CHANNELS);
            if (!w_grant_any && req[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_grant_idx    = w_idx;
                w_grant_any    = 1'b1;
            end
        end
    end

    // Move the pointer just past the channel that was served; hold otherwise.
    always_ff @(posedge clk or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            r_ptr <= '0;
        end else if (clear) begin
            r_ptr <= '0;
        end else if (accept && w_grant_any) begin
            r_ptr <= c_ptr_width'(next_rr_index(32'(w_grant_idx), NUM_CHANNELS));
        end
    end

    assign grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/machine_result_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : machine_result_aggregator
// Brief    : Buffers one result per compute-unit channel, merges channels via
//            a round-robin arbiter into one accumulator, and flags completion
//            once every dispatched machine has returned its result.
// Revision : 1.0 - initial release
// ============================================================================
module machine_result_aggregator
    import aggregator_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned RESULT_WIDTH = c_default_result_width,
    parameter int unsigned ACC_WIDTH    = c_default_acc_width,
    parameter int unsigned COUNT_WIDTH  = c_default_count_width
) (
    input  logic                                 clk,
    input  logic                                 test_logic_reset_n,
    input  logic                                 clear,
    input  logic                                 machine_dispatched,
    input  logic                                 end_of_file,
    input  logic [NUM_CHANNELS-1:0]              result_valid,
    input  logic [NUM_CHANNELS*RESULT_WIDTH-1:0] result_data,
    output logic [NUM_CHANNELS-1:0]              channel_busy,
    output logic                                 sum_valid,
    output logic [ACC_WIDTH-1:0]                 sum_data,
    output logic [COUNT_WIDTH-1:0]               result_count,
    output logic                                 overflow,
    output logic                                 protocol_error
);

    localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;

    logic [RESULT_WIDTH-1:0] r_slot_data [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_busy;
    logic [COUNT_WIDTH-1:0]  r_dispatched_count;
    logic [COUNT_WIDTH-1:0]  r_result_count;
    logic [ACC_WIDTH-1:0]    r_sum;
    logic                    r_overflow;
    logic                    r_protocol_error;
    logic                    r_sum_valid;
    agg_state_t              r_state;

    logic [NUM_CHANNELS-1:0] w_grant;
    logic [NUM_CHANNELS-1:0] w_capture;
    logic [NUM_CHANNELS-1:0] w_drop_vec;
    logic [RESULT_WIDTH-1:0] w_grant_data;
    logic [ACC_WIDTH:0]      w_sum_ext;
    logic                    w_accept;
    logic                    w_in_done;
    logic                    w_grant_any;
    logic                    w_late;
    logic                    w_sat_error;
    logic                    w_complete;

    rr_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_arbiter (
        .clk                (clk),
        .test_logic_reset_n (test_logic_reset_n),
        .clear              (clear),
        .req                (r_busy),
        .accept             (w_accept),
        .grant              (w_grant)
    );

    assign w_accept    = ~clear;
    assign w_in_done   = (r_state == ST_DONE);
    assign w_grant_any = |w_grant;

    // A strobe is taken if its slot is free or is being drained this cycle;
    // otherwise it is lost. Once DONE, strobes are ignored (and flagged late).
    assign w_capture  = w_in_done ? '0 : (result_valid & (~r_busy | w_grant));
    assign w_drop_vec = w_in_done ? '0 : (result_valid & r_busy & ~w_grant);
    assign w_late     = w_in_done && (machine_dispatched || (|result_valid));

    assign w_sat_error = (!w_in_done && machine_dispatched && (r_dispatched_count == c_count_max))
                       || (w_grant_any && (r_result_count == c_count_max));

    assign w_complete = end_of_file && (r_dispatched_count == r_result_count) && !(|r_busy);

    // Grant is one-hot, so OR-ing the gated slots forms the data mux.
    always_comb begin
        w_grant_data = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_grant_data = w_grant_data | r_slot_data[i];
            end
        end
    end

    assign w_sum_ext = {1'b0, r_sum} + {{(ACC_WIDTH + 1 - RESULT_WIDTH){1'b0}}, w_grant_data};

    // One-deep pending slot per channel, drained by the arbiter.
    always_ff @(posedge clk or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            r_busy <= '0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) r_slot_data[i] <= '0;
        end else if (clear) begin
            r_busy <= '0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) r_slot_data[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                if (w_capture[i]) begin
                    r_busy[i]      <= 1'b1;
                    r_slot_data[i] <= result_data[i*RESULT_WIDTH +: RESULT_WIDTH];
                end else if (w_grant[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Accumulator, saturating counters and sticky flags.
    always_ff @(posedge clk or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            r_sum              <= '0;
            r_overflow         <= 1'b0;
            r_result_count     <= '0;
            r_dispatched_count <= '0;
            r_protocol_error   <= 1'b0;
        end else if (clear) begin
            r_sum              <= '0;
            r_overflow         <= 1'b0;
            r_result_count     <= '0;
            r_dispatched_count <= '0;
            r_protocol_error   <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_sum <= w_sum_ext[ACC_WIDTH-1:0];
                if (w_sum_ext[ACC_WIDTH]) r_overflow <= 1'b1;
                if (r_result_count != c_count_max) r_result_count <= r_result_count + COUNT_WIDTH'(1);
            end
            if (machine_dispatched && !w_in_done && (r_dispatched_count != c_count_max)) begin
                r_dispatched_count <= r_dispatched_count + COUNT_WIDTH'(1);
            end
            if ((|w_drop_vec) || w_late || w_sat_error) r_protocol_error <= 1'b1;
        end
    end

    // Completion tracking; sum_valid is registered alongside the state.
    always_ff @(posedge clk or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            r_state     <= ST_IDLE;
            r_sum_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_sum_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_complete) begin
                        r_state     <= ST_DONE;
                        r_sum_valid <= 1'b1;
                    end else if (machine_dispatched || (|result_valid)) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_complete) begin
                        r_state     <= ST_DONE;
                        r_sum_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_DONE;
                    r_sum_valid <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_sum_valid <= 1'b0;
                end
            endcase
        end
    end

    assign channel_busy   = r_busy;
    assign sum_valid      = r_sum_valid;
    assign sum_data       = r_sum;
    assign result_count   = r_result_count;
    assign overflow       = r_overflow;
    assign protocol_error = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_machine_result_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : tb_machine_result_aggregator
// Brief    : Self-checking bench; expected accumulator states are queued when
//            results are driven and compared whenever result_count advances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_machine_result_aggregator;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned RW     = 16;
    localparam int unsigned AW     = 16;
    localparam int unsigned CW     = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clear;
    logic                 machine_dispatched;
    logic                 end_of_file;
    logic [NUM_CH-1:0]    result_valid;
    logic [NUM_CH*RW-1:0] result_data;
    logic [NUM_CH-1:0]    channel_busy;
    logic                 sum_valid;
    logic [AW-1:0]        sum_data;
    logic [CW-1:0]        result_count;
    logic                 overflow;
    logic                 protocol_error;

    int n_vec    = 0;
    int n_miscmp = 0;

    logic [AW-1:0] exp_sum;
    logic [CW-1:0] exp_cnt;
    logic [AW-1:0] q_sum [$];
    logic [CW-1:0] q_cnt [$];
    logic [CW-1:0] prev_count = '0;

    machine_result_aggregator #(
        .NUM_CHANNELS (NUM_CH),
        .RESULT_WIDTH (RW),
        .ACC_WIDTH    (AW),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk                (clk),
        .test_logic_reset_n (rst_n),
        .clear              (clear),
        .machine_dispatched (machine_dispatched),
        .end_of_file        (end_of_file),
        .result_valid       (result_valid),
        .result_data        (result_data),
        .channel_busy       (channel_busy),
        .sum_valid          (sum_valid),
        .sum_data           (sum_data),
        .result_count       (result_count),
        .overflow           (overflow),
        .protocol_error     (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic flush();
        exp_sum = '0;
        exp_cnt = '0;
        q_sum.delete();
        q_cnt.delete();
    endtask

    task automatic drive(input int ch, input logic [RW-1:0] v);
        result_valid[ch]         = 1'b1;
        result_data[ch*RW +: RW] = v;
    endtask

    task automatic expect_acc(input logic [RW-1:0] v);
        exp_sum = exp_sum + v;
        exp_cnt = exp_cnt + 10'd1;
        q_sum.push_back(exp_sum);
        q_cnt.push_back(exp_cnt);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        flush();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && q_cnt.size() != 0; i++) begin
            cyc();
            #1;
        end
        check("drain_queue_empty", 32'(q_cnt.size()), 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !sum_valid; i++) cyc();
        check("sum_valid_rise", 32'(sum_valid), 1);
    endtask

    // Scoreboard: each advance of result_count must match the next queued state.
    always @(negedge clk) begin
        if (result_count != prev_count && result_count != '0) begin
            if (q_cnt.size() == 0) begin
                check("unexpected_acc", 32'(result_count), 32'(prev_count));
            end else begin
                check("acc_sum", 32'(sum_data), 32'(q_sum.pop_front()));
                check("acc_count", 32'(result_count), 32'(q_cnt.pop_front()));
            end
        end
        prev_count <= result_count;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] exp_busy;

        rst_n = 1'b0; clear = 1'b0; machine_dispatched = 1'b0; end_of_file = 1'b0;
        result_valid = '0; result_data = '0;
        flush();
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_sum_valid", 32'(sum_valid), 0);
        check("rst_sum_data", 32'(sum_data), 0);
        check("rst_count", 32'(result_count), 0);
        check("rst_busy", 32'(channel_busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_perr", 32'(protocol_error), 0);

        // Zero machines with end_of_file: straight to DONE, sum 0.
        end_of_file = 1'b1;
        cyc();
        check("zero_sum_valid", 32'(sum_valid), 1);
        check("zero_sum_data", 32'(sum_data), 0);
        end_of_file = 1'b0;
        do_clear();
        check("clear_sum_valid", 32'(sum_valid), 0);

        // Single channel sequence.
        for (int i = 0; i < 3; i++) begin
            machine_dispatched = 1'b1; cyc();
            machine_dispatched = 1'b0; cyc();
        end
        end_of_file = 1'b1;
        drive(0, 16'd5);  expect_acc(16'd5);  cyc();
        drive(0, 16'd7);  expect_acc(16'd7);  cyc();
        drive(0, 16'd11); expect_acc(16'd11); cyc();
        result_valid = '0;
        check("t1_not_done_early", 32'(sum_valid), 0);
        wait_drain();
        wait_valid();
        check("t1_sum", 32'(sum_data), 23);
        check("t1_count", 32'(result_count), 3);
        check("t1_overflow", 32'(overflow), 0);
        check("t1_perr", 32'(protocol_error), 0);
        end_of_file = 1'b0;
        do_clear();

        // Four simultaneous results drain one per cycle in channel order.
        for (int ch = 0; ch < 4; ch++) begin
            drive(ch, RW'(ch + 1));
            expect_acc(RW'(ch + 1));
        end
        cyc();
        result_valid = '0;
        exp_busy = 4'b1111;
        check("t2_busy_full", 32'(channel_busy), 32'(exp_busy));
        for (int k = 1; k <= 4; k++) begin
            cyc();
            exp_busy = {exp_busy[2:0], 1'b0};
            check("t2_busy_drain", 32'(channel_busy), 32'(exp_busy));
        end
        check("t2_sum", 32'(sum_data), 10);
        do_clear();

        // Round-robin: ch1 and ch2 re-strobe in each cycle they are granted.
        drive(1, 16'd10); drive(2, 16'd20); expect_acc(16'd10); expect_acc(16'd20); cyc();
        result_valid = '0; drive(1, 16'd11); expect_acc(16'd11); cyc();
        result_valid = '0; drive(2, 16'd21); expect_acc(16'd21); cyc();
        result_valid = '0; drive(1, 16'd12); expect_acc(16'd12); cyc();
        result_valid = '0; drive(2, 16'd22); expect_acc(16'd22); cyc();
        result_valid = '0;
        wait_drain();
        check("t3_sum", 32'(sum_data), 96);
        check("t3_perr", 32'(protocol_error), 0);
        do_clear();

        // Overflow with a 16-bit accumulator.
        drive(0, 16'hFFFF); expect_acc(16'hFFFF); cyc();
        drive(0, 16'h0002); expect_acc(16'h0002); cyc();
        result_valid = '0;
        check("t4_sum_ffff", 32'(sum_data), 32'hFFFF);
        check("t4_no_overflow_yet", 32'(overflow), 0);
        cyc();
        check("t4_sum_wrap", 32'(sum_data), 1);
        check("t4_overflow", 32'(overflow), 1);

        // Asynchronous reset between edges with a slot pending.
        drive(1, 16'h0033); cyc();
        result_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(channel_busy), 0);
        check("arst_sum", 32'(sum_data), 0);
        check("arst_count", 32'(result_count), 0);
        check("arst_overflow", 32'(overflow), 0);
        check("arst_sum_valid", 32'(sum_valid), 0);
        check("arst_perr", 32'(protocol_error), 0);
        cyc();
        rst_n = 1'b1;
        flush();
        cyc();

        // Drop: ch0 re-strobed while occupied and ch3 holds the grant.
        drive(2, 16'd1); expect_acc(16'd1); cyc();
        result_valid = '0;
        drive(0, 16'd100); drive(3, 16'd200); expect_acc(16'd200); expect_acc(16'd100); cyc();
        result_valid = '0;
        check("t5_perr_clean", 32'(protocol_error), 0);
        drive(0, 16'd50); cyc();
        result_valid = '0;
        check("t5_perr_drop", 32'(protocol_error), 1);
        check("t5_busy_after_drop", 32'(channel_busy), 32'h1);
        wait_drain();
        check("t5_sum", 32'(sum_data), 301);
        check("t5_count", 32'(result_count), 3);
        do_clear();

        // Late result after DONE.
        machine_dispatched = 1'b1; cyc();
        machine_dispatched = 1'b0;
        end_of_file = 1'b1;
        drive(0, 16'd9); expect_acc(16'd9); cyc();
        result_valid = '0;
        wait_drain();
        wait_valid();
        check("t5b_sum", 32'(sum_data), 9);
        check("t5b_perr_before", 32'(protocol_error), 0);
        drive(1, 16'd5); cyc();
        result_valid = '0;
        check("t5b_perr_late", 32'(protocol_error), 1);
        check("t5b_sum_held", 32'(sum_data), 9);
        check("t5b_busy", 32'(channel_busy), 0);
        check("t5b_count", 32'(result_count), 1);

        // Clear concurrent with strobes and a dispatch.
        end_of_file = 1'b0;
        clear = 1'b1; machine_dispatched = 1'b1;
        for (int ch = 0; ch < 4; ch++) drive(ch, 16'd7);
        cyc();
        clear = 1'b0; machine_dispatched = 1'b0; result_valid = '0;
        flush();
        check("t6_busy", 32'(channel_busy), 0);
        check("t6_sum", 32'(sum_data), 0);
        check("t6_perr", 32'(protocol_error), 0);
        check("t6_sum_valid", 32'(sum_valid), 0);
        cyc();
        check("t6_sum_after", 32'(sum_data), 0);
        check("t6_count_after", 32'(result_count), 0);
        check("t6_perr_after", 32'(protocol_error), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
